// File: rtl/seqmon_pkg.sv
// Shared types and defaults for the per-channel sequence obligation monitor.
package seqmon_pkg;

    localparam int RESP_DLY_DEF = 1;
    localparam int ACK_DLY_DEF  = 1;
    localparam int CNT_W_DEF    = 8;

    // Result of one channel's checks at a single edge.
    typedef struct packed {
        logic pass;
        logic fail_resp;
        logic fail_ack;
    } chan_status_t;

    typedef logic [CNT_W_DEF-1:0] err_cnt_t;

endpackage

// File: rtl/seqmon_chan.sv
// One channel: stage A (trigger->response) and stage B (response->ack) pipelines with checks.
module seqmon_chan
    import seqmon_pkg::*;
#(
    parameter int RESP_DLY = RESP_DLY_DEF,
    parameter int ACK_DLY  = ACK_DLY_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         resp,
    input  logic         ack,
    input  logic         abort,
    output chan_status_t status,
    output logic         fail_next,
    output logic         busy
);

    logic [RESP_DLY-1:0] a_q, a_d;
    logic [ACK_DLY-1:0]  b_q, b_d;
    chan_status_t        status_q, status_d;
    logic                a_exit, b_exit;

    assign a_exit = a_q[RESP_DLY-1];
    assign b_exit = b_q[ACK_DLY-1];

    // NOTE: every output of this block gets a default before any condition, so no latch is inferred.
    always_comb begin
        a_d[0] = start;
        for (int i = 1; i < RESP_DLY; i++) a_d[i] = a_q[i-1];
        b_d[0] = a_exit & resp;
        for (int i = 1; i < ACK_DLY; i++) b_d[i] = b_q[i-1];

        status_d.pass      = b_exit & ack;
        status_d.fail_resp = a_exit & ~resp;
        status_d.fail_ack  = b_exit & ~ack;

        // An abort discards pending attempts and any result due at this edge.
        if (abort) begin
            a_d      = '0;
            b_d      = '0;
            status_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            status_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            status_q <= status_d;
        end
    end

    assign status    = status_q;
    assign fail_next = status_d.fail_resp | status_d.fail_ack;
    assign busy      = (|a_q) | (|b_q);

endmodule

// File: rtl/seq_obligation_monitor.sv
// N-channel trigger->response->ack obligation monitor with saturating error count.
// Optional macro SEQMON_ABORT_EN: an edge sampling en=0 clears all pending attempts.
module seq_obligation_monitor
    import seqmon_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int RESP_DLY = RESP_DLY_DEF,
    parameter int ACK_DLY  = ACK_DLY_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   trig,
    input  logic [NCH-1:0]   resp,
    input  logic             ack,
    output logic [NCH-1:0]   pass,
    output logic [NCH-1:0]   fail,
    output logic             fail_any,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy
);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;

    logic         abort;
    logic [NCH-1:0] fail_next, chan_busy;
    chan_status_t st [NCH];
    cnt_t         err_cnt_q, err_cnt_d;

`ifdef SEQMON_ABORT_EN
    assign abort = ~en;
`else
    assign abort = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        seqmon_chan #(
            .RESP_DLY (RESP_DLY),
            .ACK_DLY  (ACK_DLY)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (en & trig[i]),
            .resp      (resp[i]),
            .ack       (ack),
            .abort     (abort),
            .status    (st[i]),
            .fail_next (fail_next[i]),
            .busy      (chan_busy[i])
        );
        assign pass[i] = st[i].pass;
        assign fail[i] = st[i].fail_resp | st[i].fail_ack;
    end

    // Counts from next-state fails so err_cnt and fail_any change on the same edge.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((|fail_next) && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + cnt_t'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign fail_any = |fail;
    assign err_cnt  = err_cnt_q;
    assign busy     = |chan_busy;

endmodule

// File: tb/tb_seq_obligation_monitor.sv
// Directed bench for seq_obligation_monitor (NCH=2, RESP_DLY=1, ACK_DLY=1, CNT_W=4).
module tb_seq_obligation_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] trig = '0;
    logic [1:0] resp = '0;
    logic       ack = 1'b0;
    logic [1:0] pass, fail;
    logic       fail_any, busy;
    logic [3:0] err_cnt;
    logic [9:0] obs;

    int checks = 0;
    int errors = 0;

    seq_obligation_monitor #(.NCH(2), .RESP_DLY(1), .ACK_DLY(1), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .trig     (trig),
        .resp     (resp),
        .ack      (ack),
        .pass     (pass),
        .fail     (fail),
        .fail_any (fail_any),
        .err_cnt  (err_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {pass[1:0], fail[1:0], fail_any, err_cnt[3:0], busy}
    assign obs = {pass, fail, fail_any, err_cnt, busy};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en = 1'b0; trig = '0; resp = '0; ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_0) begin
            errors++;
            $display("FAIL reset: got %b expected %b", obs, 10'b00_00_0_0000_0);
        end
        rst = 1'b0;
    endtask

    task automatic test_happy();
        do_reset();
        en = 1'b1; trig = 2'b01;
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_1) begin
            errors++; $display("FAIL happy_e0: got %b expected %b", obs, 10'b00_00_0_0000_1);
        end
        trig = 2'b00; resp = 2'b01;
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_1) begin
            errors++; $display("FAIL happy_e1: got %b expected %b", obs, 10'b00_00_0_0000_1);
        end
        resp = 2'b00; ack = 1'b1;
        tick();
        checks++;
        if (obs !== 10'b01_00_0_0000_0) begin
            errors++; $display("FAIL happy_e2: got %b expected %b", obs, 10'b01_00_0_0000_0);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_0) begin
            errors++; $display("FAIL happy_e3: got %b expected %b", obs, 10'b00_00_0_0000_0);
        end
    endtask

    task automatic test_resp_miss();
        do_reset();
        en = 1'b1; trig = 2'b10;
        tick();
        trig = 2'b00; resp = 2'b00;
        tick();
        checks++;
        if (obs !== 10'b00_10_1_0001_0) begin
            errors++; $display("FAIL resp_miss_e1: got %b expected %b", obs, 10'b00_10_1_0001_0);
        end
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0001_0) begin
            errors++; $display("FAIL resp_miss_e2: got %b expected %b", obs, 10'b00_00_0_0001_0);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        en = 1'b1; trig = 2'b01;
        tick();
        trig = 2'b01; resp = 2'b01;
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_1) begin
            errors++; $display("FAIL overlap_e1: got %b expected %b", obs, 10'b00_00_0_0000_1);
        end
        trig = 2'b00; resp = 2'b01; ack = 1'b0;
        tick();
        checks++;
        if (obs !== 10'b00_01_1_0001_1) begin
            errors++; $display("FAIL overlap_e2: got %b expected %b", obs, 10'b00_01_1_0001_1);
        end
        resp = 2'b00; ack = 1'b1;
        tick();
        checks++;
        if (obs !== 10'b01_00_0_0001_0) begin
            errors++; $display("FAIL overlap_e3: got %b expected %b", obs, 10'b01_00_0_0001_0);
        end
        ack = 1'b0;
    endtask

    // Older attempt passes its ack while the younger misses its response on the same edge.
    task automatic test_back_to_back();
        do_reset();
        en = 1'b1; trig = 2'b01;
        tick();
        trig = 2'b01; resp = 2'b01;
        tick();
        trig = 2'b00; resp = 2'b00; ack = 1'b1;
        tick();
        checks++;
        if (obs !== 10'b01_01_1_0001_0) begin
            errors++; $display("FAIL back_to_back: got %b expected %b", obs, 10'b01_01_1_0001_0);
        end
        ack = 1'b0;
    endtask

    task automatic test_gating();
        logic [3:0] exp_cnt;
        do_reset();
        en = 1'b0; trig = 2'b11; resp = 2'b11; ack = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_0) begin
            errors++; $display("FAIL gating_blocked: got %b expected %b", obs, 10'b00_00_0_0000_0);
        end
        en = 1'b1; trig = 2'b11; resp = 2'b00; ack = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            tick();
            exp_cnt = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            checks++;
            if (err_cnt !== exp_cnt || fail_any !== (k >= 2)) begin
                errors++;
                $display("FAIL saturate_k%0d: got cnt=%0d any=%b expected cnt=%0d any=%b",
                         k, err_cnt, fail_any, exp_cnt, (k >= 2));
            end
        end
        en = 1'b0; trig = 2'b00;
    endtask

    task automatic test_abort();
        do_reset();
        en = 1'b1; trig = 2'b11;
        tick();
        en = 1'b0; trig = 2'b00; resp = 2'b11;
        tick();
`ifdef SEQMON_ABORT_EN
        checks++;
        if (obs !== 10'b00_00_0_0000_0) begin
            errors++; $display("FAIL abort_e1: got %b expected %b", obs, 10'b00_00_0_0000_0);
        end
`else
        checks++;
        if (obs !== 10'b00_00_0_0000_1) begin
            errors++; $display("FAIL abort_e1: got %b expected %b", obs, 10'b00_00_0_0000_1);
        end
`endif
        resp = 2'b00; ack = 1'b1;
        tick();
`ifdef SEQMON_ABORT_EN
        checks++;
        if (obs !== 10'b00_00_0_0000_0) begin
            errors++; $display("FAIL abort_e2: got %b expected %b", obs, 10'b00_00_0_0000_0);
        end
`else
        checks++;
        if (obs !== 10'b11_00_0_0000_0) begin
            errors++; $display("FAIL abort_e2: got %b expected %b", obs, 10'b11_00_0_0000_0);
        end
`endif
        ack = 1'b0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        en = 1'b1; trig = 2'b11;
        tick();
        checks++;
        if (obs !== 10'b00_00_0_0000_1) begin
            errors++; $display("FAIL midreset_pre: got %b expected %b", obs, 10'b00_00_0_0000_1);
        end
        trig = 2'b00; en = 1'b0;
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== 10'b00_00_0_0000_0) begin
            errors++; $display("FAIL midreset_async: got %b expected %b", obs, 10'b00_00_0_0000_0);
        end
        tick();
        rst = 1'b0; resp = 2'b00; ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (obs !== 10'b00_00_0_0000_0) begin
                errors++; $display("FAIL midreset_after%0d: got %b expected %b", k, obs, 10'b00_00_0_0000_0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_resp_miss();
        test_overlap();
        test_back_to_back();
        test_gating();
        test_abort();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_obligation_monitor.md
# seq_obligation_monitor

Synthesizable N-channel sequence monitor that checks per channel, in hardware, the obligation "trigger implies response RESP_DLY cycles later, then global acknowledge ACK_DLY cycles after that". It is gated by an activation condition. It sits beside the datapath under test and drives pass/fail pulses, a saturating error counter and a busy flag into the debug/status fabric. It generalises the fixed two-bit, one-cycle check to parametrised channel count and delays, with overlapping attempts and error reporting.

## Interface
- NCH, 2, number of independent channels (>=1)
- RESP_DLY, 1, edges from trigger sample to response sample (>=1)
- ACK_DLY, 1, edges from response sample to ack sample (>=1)
- CNT_W, 8, error counter width (>=2)
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  activation condition; triggers are accepted only while high
- trig  input  NCH  per-channel trigger (antecedent)
- resp  input  NCH  per-channel response
- ack  input  1  global acknowledge shared by all channels
- pass  output  NCH  one-cycle pulse: obligation on channel i completed
- fail  output  NCH  one-cycle pulse: obligation on channel i violated
- fail_any  output  1  OR of fail
- err_cnt  output  CNT_W  saturating count of cycles with fail_any
- busy  output  1  any obligation pending on any channel

## Operation
- Attempt start: at each edge where en=1 and trig[i]=1, one new obligation is started for channel i. A new attempt starts every such edge; attempts overlap freely.
- Each channel holds two shift pipelines: stage A (RESP_DLY bits) and stage B (ACK_DLY bits). A bit marks one pending attempt.
- Response check: at the edge where an attempt exits stage A, resp[i] is sampled. If resp[i]=1, the attempt enters stage B. If resp[i]=0, the attempt is dropped and fail[i] fires.
- Ack check: at the edge where an attempt exits stage B, ack is sampled. If ack=1, pass[i] fires. If ack=0, fail[i] fires.
- Simultaneous exits on one channel: a response failure of a younger attempt and an ack result of an older attempt can occur on the same edge. fail[i] is the OR of both failure sources. pass[i] and fail[i] may both be 1 in the same cycle.
- err_cnt adds 1 per edge with any fail, regardless of how many channels or attempts failed. It holds at 2^CNT_W-1 once reached.
- en=0 blocks new attempts only; pending attempts run to completion (build without SEQMON_ABORT_EN).
- busy = OR of all stage A and stage B bits.

## Timing
- Reset values: pass=0, fail=0, fail_any=0, err_cnt=0, busy=0, all pipeline bits 0. Reset asserted mid-operation discards every pending attempt, and no pulses are issued for them.
- Trigger sampled at edge e0 -> resp sampled at e0+RESP_DLY -> ack sampled at e0+RESP_DLY+ACK_DLY.
- pass/fail are registered at the deciding edge and stay high for exactly one cycle after it.
- A resp failure is visible after edge e0+RESP_DLY. A pass or ack failure is visible after edge e0+RESP_DLY+ACK_DLY.
- err_cnt updates on the same edge as fail_any, so both are visible in the same cycle.
- busy rises after the trigger edge and falls after the last deciding edge.

## Configuration
- SEQMON_ABORT_EN defined: an edge sampling en=0 clears all stage A/B bits on every channel. No pass or fail is issued for cleared attempts, and checks already due at that edge are discarded. busy falls in the next cycle.
- SEQMON_ABORT_EN undefined: en only gates new attempts, as described in Operation.

## Structure
- Package seqmon_pkg:
  - localparam defaults for the delays
  - typedef for the per-channel status struct {pass, fail_resp, fail_ack}
  - typedef for the counter type parametrised by CNT_W
- Sub-module seqmon_chan: one channel's stage A/B pipelines and check logic, generated NCH times.
- The top level holds the fail_any OR, err_cnt, busy reduction and the abort macro handling.

## Test plan
All scenarios use NCH=2, RESP_DLY=1, ACK_DLY=1, CNT_W=4 unless stated otherwise.
- Happy path: en=1, trig=01 at e0; resp=01 at e1; ack=1 at e2 -> pass=01 after e2, fail=00, err_cnt=0, busy high after e0 and after e1, low after e2.
- Response miss: trig=10 at e0, resp=00 at e1 -> fail=10 and fail_any=1 after e1, err_cnt=1, no pass.
- Overlap: trig=01 at e0 and at e1; resp=01 at e1 and e2; ack=0 at e2, 1 at e3 -> fail=01 after e2, pass=01 after e3, err_cnt=1.
- Gating: en=0 with trig=11 -> no attempt starts, busy=0. Then 20 consecutive failing cycles -> err_cnt saturates at 15.
- Abort (SEQMON_ABORT_EN defined): trig=11 at e0, en=0 at e1 -> no pass or fail issued, busy=0 after e1. The same stimulus without the macro -> the checks complete normally.
- Reset mid-flight: trig=11 at e0, rst pulsed before e1 -> all outputs 0, no pulses afterwards.
